// File: rtl/dawson_pkg.sv
// dawson_pkg: shared state enum, default datapath width and the quiet-NaN timeout result
package dawson_pkg;
  typedef enum logic [1:0] {ST_COLLECT, ST_START, ST_COMPUTE, ST_PUT_Z} dawson_resp_state_t;
  localparam int DAWSON_WIDTH = 64;
  localparam logic [63:0] DAWSON_QNAN = 64'h7FF8_0000_0000_0000;
endpackage

// File: rtl/dawson_operand_slot.sv
// dawson_operand_slot: one operand channel (stb/data in, registered ack out, held flag, captured data q; clear releases)
module dawson_operand_slot
  import dawson_pkg::*;
#(
  parameter int WIDTH = DAWSON_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stb,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             ack,
  output logic             held,
  output logic [WIDTH-1:0] q
);
  logic held_d, held_q, ack_d, ack_q;
  logic [WIDTH-1:0] data_d, data_q;
  always_comb begin
    held_d = clear ? 1'b0 : held_q | (stb & ack_q);
    data_d = (stb & ack_q) ? data : data_q;
    ack_d  = ~held_d;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= 1'b0;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end
  assign ack  = ack_q;
  assign held = held_q;
  assign q    = data_q;
endmodule

// File: rtl/dawson_unit_responder.sv
// dawson_unit_responder: unit-side strobe/ack responder (operands a/b in, result z out, core start/done launch, sticky watchdog timeout_err)
module dawson_unit_responder
  import dawson_pkg::*;
#(
  parameter int WIDTH          = DAWSON_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  dawson_resp_state_t state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] z_d, z_q;
  logic err_d, err_q, start_d, start_q, zstb_d, zstb_q, clear, a_held, b_held;
  dawson_operand_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clock(clock), .reset_n(reset_n), .stb(input_a_stb), .data(input_a),
    .clear(clear), .ack(input_a_ack), .held(a_held), .q(core_a)
  );
  dawson_operand_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clock(clock), .reset_n(reset_n), .stb(input_b_stb), .data(input_b),
    .clear(clear), .ack(input_b_ack), .held(b_held), .q(core_b)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      ST_COLLECT: state_d = ((a_held | (input_a_stb & input_a_ack)) &
                             (b_held | (input_b_stb & input_b_ack))) ? ST_START : ST_COLLECT;
      ST_START: begin
        state_d = ST_COMPUTE;
        cnt_d   = '0;
      end
      ST_COMPUTE:
        if (core_done) begin
          z_d     = core_result;
          state_d = ST_PUT_Z;
        end else if (cnt_q == LAST) begin
          z_d     = WIDTH'(DAWSON_QNAN);
          err_d   = 1'b1;
          state_d = ST_PUT_Z;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      ST_PUT_Z: state_d = output_z_ack ? ST_COLLECT : ST_PUT_Z;
      default: state_d = ST_COLLECT;
    endcase
    start_d = state_d == ST_START;
    zstb_d  = state_d == ST_PUT_Z;
  end
  assign clear = (state_q == ST_PUT_Z) & output_z_ack;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      zstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      err_q   <= err_d;
      start_q <= start_d;
      zstb_q  <= zstb_d;
    end
  end
  assign output_z     = z_q;
  assign output_z_stb = zstb_q;
  assign core_start   = start_q;
  assign timeout_err  = err_q;
endmodule

// File: tb/tb_dawson_unit_responder.sv
// tb_dawson_unit_responder: directed self-checking bench for dawson_unit_responder
module tb_dawson_unit_responder;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [63:0] input_a = '0, input_b = '0, core_result = '0;
  logic input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0, core_done = 1'b0;
  logic input_a_ack, input_b_ack, output_z_stb, core_start, timeout_err;
  logic [63:0] output_z, core_a, core_b;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  dawson_unit_responder #(.WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .core_a(core_a), .core_b(core_b), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .timeout_err(timeout_err)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_a_ack"}, 64'(input_a_ack), 64'd1);
    chk({tag, "_b_ack"}, 64'(input_b_ack), 64'd1);
    chk({tag, "_z_stb"}, 64'(output_z_stb), 64'd0);
  endtask
  initial begin
    #12;
    chk("rst_a_ack", 64'(input_a_ack), 64'd0);
    chk("rst_b_ack", 64'(input_b_ack), 64'd0);
    chk("rst_z_stb", 64'(output_z_stb), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    chk("rst_z", output_z, 64'd0);
    chk("rst_core_a", core_a, 64'd0);
    reset_n = 1'b1;
    tick();
    chk_idle("release");
    // same-cycle operands, core answers k=2
    input_a = 64'd1; input_b = 64'd2; input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    chk("t1_start", 64'(core_start), 64'd1);
    chk("t1_core_a", core_a, 64'd1);
    chk("t1_core_b", core_b, 64'd2);
    chk("t1_a_ack_low", 64'(input_a_ack), 64'd0);
    tick();
    chk("t1_start_pulse", 64'(core_start), 64'd0);
    tick();
    core_done = 1'b1; core_result = 64'd3;
    tick();
    core_done = 1'b0;
    chk("t1_z_stb", 64'(output_z_stb), 64'd1);
    chk("t1_z", output_z, 64'd3);
    tick();
    chk("t1_z_hold", output_z, 64'd3);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk_idle("t1_done");
    // B three cycles ahead of A, core answers k=1
    input_b = 64'd2; input_b_stb = 1'b1;
    tick();
    input_b_stb = 1'b0;
    chk("t2_b_ack_low", 64'(input_b_ack), 64'd0);
    chk("t2_a_ack_high", 64'(input_a_ack), 64'd1);
    tick();
    tick();
    chk("t2_wait_a", 64'(core_start), 64'd0);
    input_a = 64'd3; input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    chk("t2_start", 64'(core_start), 64'd1);
    chk("t2_core_a", core_a, 64'd3);
    chk("t2_core_b", core_b, 64'd2);
    tick();
    core_done = 1'b1; core_result = 64'd5;
    tick();
    core_done = 1'b0;
    chk("t2_z", output_z, 64'd5);
    // initiator stalls the result; stray done and stb must be ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin core_done = 1'b1; core_result = 64'd9; input_a_stb = 1'b1; input_a = 64'd77; end
      tick();
      core_done = 1'b0; input_a_stb = 1'b0;
      chk("t3_z_stb", 64'(output_z_stb), 64'd1);
      chk("t3_z", output_z, 64'd5);
      chk("t3_a_ack", 64'(input_a_ack), 64'd0);
    end
    chk("t3_core_a", core_a, 64'd3);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk_idle("t3_done");
    // watchdog expiry with TIMEOUT_CYCLES=4
    input_a = 64'd1; input_b = 64'd1; input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_no_early", 64'(output_z_stb), 64'd0);
    tick();
    chk("t4_z_stb", 64'(output_z_stb), 64'd1);
    chk("t4_z_qnan", output_z, QNAN);
    chk("t4_err", 64'(timeout_err), 64'd1);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    input_a = 64'd1; input_b = 64'd2; input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    tick();
    core_done = 1'b1; core_result = 64'd3;
    tick();
    core_done = 1'b0;
    chk("t4b_z", output_z, 64'd3);
    chk("t4b_err_sticky", 64'(timeout_err), 64'd1);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    // reset during COMPUTE
    input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("r1_err", 64'(timeout_err), 64'd0);
    chk("r1_start", 64'(core_start), 64'd0);
    chk("r1_z_stb", 64'(output_z_stb), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    chk_idle("r1_release");
    core_done = 1'b1; core_result = 64'd66;
    tick();
    core_done = 1'b0;
    chk("r1_late_done", 64'(output_z_stb), 64'd0);
    chk("r1_late_z", output_z, 64'd0);
    // done on the expiry edge wins
    input_a = 64'd4; input_b = 64'd5; input_a_stb = 1'b1; input_b_stb = 1'b1;
    tick();
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    core_done = 1'b1; core_result = 64'hAB;
    tick();
    core_done = 1'b0;
    chk("t5_z_stb", 64'(output_z_stb), 64'd1);
    chk("t5_z", output_z, 64'hAB);
    chk("t5_err", 64'(timeout_err), 64'd0);
    // reset during PUT_Z
    tick();
    reset_n = 1'b0;
    #1;
    chk("r2_z_stb", 64'(output_z_stb), 64'd0);
    chk("r2_z", output_z, 64'd0);
    chk("r2_core_b", core_b, 64'd0);
    #2 reset_n = 1'b1;
    tick();
    chk_idle("r2_release");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
